// File: rtl/sal_rd_return.sv
// ---------------------------------------------------------------------------
// sal_rd_return
//
// Read-return path between the DFI read data bus and an AXI R channel.
// The scheduler posts one tag (AXI ID + burst length) per issued RD burst.
// DFI read beats arrive later with no backpressure. This block pairs the
// queued tags with the queued beats and replays them on the AXI R channel.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   tag_valid/ready   : tag push handshake (tag_id, tag_len = beats-1)
//   dfi_rddata_valid  : DFI beat strobe, dfi_rddata is the beat
//   rvalid/rready     : AXI R handshake, with rid/rdata/rresp/rlast
//   data_free         : registered count of free data FIFO entries,
//                       used by the scheduler as its read credit
//   ovf               : sticky, set when a DFI beat had to be dropped
//   idle              : both FIFOs empty and the FSM is idle
//
// Optional feature
//   SAL_RD_PARITY_EN  : adds input dfi_rddata_par (one even-parity bit per
//                       byte). Parity travels with the beat through the data
//                       FIFO and a bad byte returns SLVERR on that beat only.
//                       Without it, rresp is always OKAY.
// ---------------------------------------------------------------------------
module sal_rd_return #(
    parameter int DATA_W     = 64,
    parameter int ID_W       = 4,
    parameter int TAG_DEPTH  = 8,
    parameter int DATA_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tag_valid,
    output logic                          tag_ready,
    input  logic [ID_W-1:0]               tag_id,
    input  logic [3:0]                    tag_len,
    input  logic                          dfi_rddata_valid,
    input  logic [DATA_W-1:0]             dfi_rddata,
`ifdef SAL_RD_PARITY_EN
    input  logic [DATA_W/8-1:0]           dfi_rddata_par,
`endif
    output logic                          rvalid,
    input  logic                          rready,
    output logic [ID_W-1:0]               rid,
    output logic [DATA_W-1:0]             rdata,
    output logic [1:0]                    rresp,
    output logic                          rlast,
    output logic [$clog2(DATA_DEPTH):0]   data_free,
    output logic                          ovf,
    output logic                          idle
);

    localparam int TAG_AW  = $clog2(TAG_DEPTH);
    localparam int DATA_AW = $clog2(DATA_DEPTH);
    localparam int FREE_W  = DATA_AW + 1;

    localparam logic [TAG_AW:0]   TAG_PTR_ONE  = (TAG_AW + 1)'(1);
    localparam logic [DATA_AW:0]  DATA_PTR_ONE = (DATA_AW + 1)'(1);
    localparam logic [FREE_W-1:0] FREE_ONE     = FREE_W'(1);
    localparam logic [FREE_W-1:0] FREE_MAX     = FREE_W'(DATA_DEPTH);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t state;
    state_t state_nxt;

    // Tag FIFO storage and pointers (pointers carry one extra wrap bit)
    logic [ID_W-1:0]   tag_id_mem  [TAG_DEPTH];
    logic [3:0]        tag_len_mem [TAG_DEPTH];
    logic [TAG_AW:0]   tag_wr_ptr;
    logic [TAG_AW:0]   tag_rd_ptr;
    logic [TAG_AW:0]   tag_count;
    logic              tag_full;
    logic              tag_empty;
    logic              tag_push;
    logic              tag_pop;

    // Data FIFO storage and pointers
    logic [DATA_W-1:0] data_mem [DATA_DEPTH];
    logic [DATA_AW:0]  data_wr_ptr;
    logic [DATA_AW:0]  data_rd_ptr;
    logic              data_full;
    logic              data_empty;
    logic              data_push;
    logic              data_drop;
    logic [FREE_W-1:0] data_free_q;

    // Burst tracking and R channel internals
    logic [3:0]        beat_cnt;
    logic              ovf_q;
    logic [ID_W-1:0]   head_id;
    logic [3:0]        head_len;
    logic [DATA_W-1:0] head_data;
    logic              r_valid_int;
    logic              r_last_int;
    logic              r_pop;
    logic              beat_err;

    // ------------------------------------------------------------------
    // FIFO status
    // ------------------------------------------------------------------
    assign tag_full   = (tag_wr_ptr[TAG_AW] != tag_rd_ptr[TAG_AW]) &&
                        (tag_wr_ptr[TAG_AW-1:0] == tag_rd_ptr[TAG_AW-1:0]);
    assign tag_empty  = (tag_wr_ptr == tag_rd_ptr);
    assign tag_count  = tag_wr_ptr - tag_rd_ptr;

    assign data_full  = (data_wr_ptr[DATA_AW] != data_rd_ptr[DATA_AW]) &&
                        (data_wr_ptr[DATA_AW-1:0] == data_rd_ptr[DATA_AW-1:0]);
    assign data_empty = (data_wr_ptr == data_rd_ptr);

    assign head_id    = tag_id_mem[tag_rd_ptr[TAG_AW-1:0]];
    assign head_len   = tag_len_mem[tag_rd_ptr[TAG_AW-1:0]];
    assign head_data  = data_mem[data_rd_ptr[DATA_AW-1:0]];

    // ------------------------------------------------------------------
    // Handshakes. Outputs are forced to their reset values while rst is
    // high so the scheduler sees a quiet block for the whole reset cycle,
    // not only after the first reset edge.
    // ------------------------------------------------------------------
    assign tag_ready   = !rst && !tag_full;
    assign tag_push    = tag_valid && tag_ready;

    assign r_valid_int = !rst && (state == STREAM) && !data_empty;
    assign r_last_int  = r_valid_int && (beat_cnt == head_len);
    assign r_pop       = r_valid_int && rready;
    assign tag_pop     = r_pop && r_last_int;

    // A full data FIFO can still take a beat when the head is leaving in
    // the same cycle: the write lands in the slot being vacated.
    assign data_push   = !rst && dfi_rddata_valid && (!data_full || r_pop);
    assign data_drop   = !rst && dfi_rddata_valid && data_full && !r_pop;

`ifdef SAL_RD_PARITY_EN
    logic [DATA_W/8-1:0] par_mem [DATA_DEPTH];
    logic [DATA_W/8-1:0] head_par;

    assign head_par = par_mem[data_rd_ptr[DATA_AW-1:0]];

    // Parity bits are written next to their beat
    always_ff @(posedge clk) begin
        if (data_push) begin
            par_mem[data_wr_ptr[DATA_AW-1:0]] <= dfi_rddata_par;
        end
    end

    // Even parity: a byte plus its parity bit must hold an even number of ones
    always_comb begin
        beat_err = 1'b0;
        for (int b = 0; b < DATA_W / 8; b++) begin
            if ((^head_data[8*b +: 8]) != head_par[b]) begin
                beat_err = 1'b1;
            end
        end
    end
`else
    assign beat_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // R channel outputs. Everything comes straight from FIFO heads and
    // beat_cnt, which only move on a handshake, so the channel is stable
    // while rvalid && !rready.
    // ------------------------------------------------------------------
    assign rvalid    = r_valid_int;
    assign rlast     = r_last_int;
    assign rid       = rst ? '0 : head_id;
    assign rdata     = head_data;
    assign rresp     = (r_valid_int && beat_err) ? 2'b10 : 2'b00;
    assign data_free = rst ? FREE_MAX : data_free_q;
    assign ovf       = !rst && ovf_q;
    assign idle      = rst || ((state == IDLE) && tag_empty && data_empty);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state. STREAM is left only when the burst that just ended
    // was the last queued tag and no new tag is arriving this cycle, so
    // back-to-back bursts stream without a gap.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!tag_empty) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (tag_pop && (tag_count == TAG_PTR_ONE) && !tag_push) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Tag FIFO pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_wr_ptr <= '0;
            tag_rd_ptr <= '0;
        end else begin
            if (tag_push) begin
                tag_wr_ptr <= tag_wr_ptr + TAG_PTR_ONE;
            end
            if (tag_pop) begin
                tag_rd_ptr <= tag_rd_ptr + TAG_PTR_ONE;
            end
        end
    end

    // Tag FIFO storage, contents are don't-care until written
    always_ff @(posedge clk) begin
        if (tag_push) begin
            tag_id_mem[tag_wr_ptr[TAG_AW-1:0]]  <= tag_id;
            tag_len_mem[tag_wr_ptr[TAG_AW-1:0]] <= tag_len;
        end
    end

    // ------------------------------------------------------------------
    // Data FIFO pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            data_wr_ptr <= '0;
            data_rd_ptr <= '0;
        end else begin
            if (data_push) begin
                data_wr_ptr <= data_wr_ptr + DATA_PTR_ONE;
            end
            if (r_pop) begin
                data_rd_ptr <= data_rd_ptr + DATA_PTR_ONE;
            end
        end
    end

    // Data FIFO storage
    always_ff @(posedge clk) begin
        if (data_push) begin
            data_mem[data_wr_ptr[DATA_AW-1:0]] <= dfi_rddata;
        end
    end

    // ------------------------------------------------------------------
    // Free-entry credit, tracked alongside the pointers so the scheduler
    // gets a registered value. Push and pop together cancel out.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            data_free_q <= FREE_MAX;
        end else begin
            case ({data_push, r_pop})
                2'b10:   data_free_q <= data_free_q - FREE_ONE;
                2'b01:   data_free_q <= data_free_q + FREE_ONE;
                default: data_free_q <= data_free_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Beat counter within the current burst; rolls back to zero on rlast
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= 4'd0;
        end else if (r_pop) begin
            if (r_last_int) begin
                beat_cnt <= 4'd0;
            end else begin
                beat_cnt <= beat_cnt + 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky overflow: only reset clears it
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (data_drop) begin
            ovf_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sal_rd_return.sv
// ---------------------------------------------------------------------------
// tb_sal_rd_return
//
// Self-checking bench for sal_rd_return. R beats are checked against a
// scoreboard queue filled as stimulus is driven; scenario tasks add their own
// timing, credit, overflow and reset checks. Build with +define+SAL_RD_PARITY_EN
// to include the parity scenario.
// ---------------------------------------------------------------------------
module tb_sal_rd_return;

    localparam int DATA_W     = 64;
    localparam int ID_W       = 4;
    localparam int TAG_DEPTH  = 8;
    localparam int DATA_DEPTH = 16;
    localparam int FREE_W     = $clog2(DATA_DEPTH) + 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 tag_valid;
    logic                 tag_ready;
    logic [ID_W-1:0]      tag_id;
    logic [3:0]           tag_len;
    logic                 dfi_rddata_valid;
    logic [DATA_W-1:0]    dfi_rddata;
`ifdef SAL_RD_PARITY_EN
    logic [DATA_W/8-1:0]  dfi_rddata_par;
`endif
    logic                 rvalid;
    logic                 rready;
    logic [ID_W-1:0]      rid;
    logic [DATA_W-1:0]    rdata;
    logic [1:0]           rresp;
    logic                 rlast;
    logic [FREE_W-1:0]    data_free;
    logic                 ovf;
    logic                 idle;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic              last;
        logic [1:0]        resp;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    sal_rd_return #(
        .DATA_W     (DATA_W),
        .ID_W       (ID_W),
        .TAG_DEPTH  (TAG_DEPTH),
        .DATA_DEPTH (DATA_DEPTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .tag_valid        (tag_valid),
        .tag_ready        (tag_ready),
        .tag_id           (tag_id),
        .tag_len          (tag_len),
        .dfi_rddata_valid (dfi_rddata_valid),
        .dfi_rddata       (dfi_rddata),
`ifdef SAL_RD_PARITY_EN
        .dfi_rddata_par   (dfi_rddata_par),
`endif
        .rvalid           (rvalid),
        .rready           (rready),
        .rid              (rid),
        .rdata            (rdata),
        .rresp            (rresp),
        .rlast            (rlast),
        .data_free        (data_free),
        .ovf              (ovf),
        .idle             (idle)
    );

    // Scoreboard comparator: every R handshake must match the oldest expected beat
    always @(negedge clk) begin
        if (rvalid === 1'b1 && rready === 1'b1) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("[TB] FAIL r_unexpected: got beat id=%0h data=%h last=%0b, required no beat",
                         rid, rdata, rlast);
            end else begin
                mon_e = sb.pop_front();
                if (rid !== mon_e.id || rdata !== mon_e.data ||
                    rlast !== mon_e.last || rresp !== mon_e.resp) begin
                    n_err++;
                    $display("[TB] FAIL r_beat: got id=%0h data=%h last=%0b resp=%0b, required id=%0h data=%h last=%0b resp=%0b",
                             rid, rdata, rlast, rresp, mon_e.id, mon_e.data, mon_e.last, mon_e.resp);
                end
            end
        end
    end

    // Hard stop in case the run wedges
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance past the next rising edge; inputs are driven just after it
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Settle point for output checks, away from the rising edge
    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [DATA_W-1:0] d, input logic bad_par);
        dfi_rddata_valid = 1'b1;
        dfi_rddata       = d;
`ifdef SAL_RD_PARITY_EN
        for (int b = 0; b < DATA_W / 8; b++) begin
            dfi_rddata_par[b] = ^d[8*b +: 8];
        end
        if (bad_par) begin
            dfi_rddata_par[0] = ~dfi_rddata_par[0];
        end
`else
        if (bad_par) begin
            $display("[TB] note: parity corruption requested in a build without parity");
        end
`endif
    endtask

    function automatic exp_t mk_exp(input logic [ID_W-1:0] id, input logic [DATA_W-1:0] d,
                                    input logic last, input logic [1:0] resp);
        exp_t e;
        e.id   = id;
        e.data = d;
        e.last = last;
        e.resp = resp;
        return e;
    endfunction

    // Run until every expected beat has come out and rvalid has dropped
    task automatic drain(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            cyc();
            sample();
            if (sb.size() == 0 && rvalid === 1'b0) begin
                done = 1'b1;
            end
        end
        n_vec++;
        if (!done) begin
            n_err++;
            $display("[TB] FAIL %s_drain: %0d beats pending, rvalid=%0b, required 0 pending and rvalid=0",
                     name, sb.size(), rvalid);
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        sample();
        n_vec++; if (rvalid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_rvalid: got %0b required 0", rvalid); end
        n_vec++; if (rlast !== 1'b0) begin n_err++; $display("[TB] FAIL reset_rlast: got %0b required 0", rlast); end
        n_vec++; if (rid !== '0) begin n_err++; $display("[TB] FAIL reset_rid: got %0h required 0", rid); end
        n_vec++; if (rresp !== 2'b00) begin n_err++; $display("[TB] FAIL reset_rresp: got %0b required 00", rresp); end
        n_vec++; if (ovf !== 1'b0) begin n_err++; $display("[TB] FAIL reset_ovf: got %0b required 0", ovf); end
        n_vec++; if (tag_ready !== 1'b0) begin n_err++; $display("[TB] FAIL reset_tag_ready: got %0b required 0", tag_ready); end
        n_vec++; if (data_free !== FREE_W'(DATA_DEPTH)) begin n_err++; $display("[TB] FAIL reset_data_free: got %0d required %0d", data_free, DATA_DEPTH); end
        n_vec++; if (idle !== 1'b1) begin n_err++; $display("[TB] FAIL reset_idle: got %0b required 1", idle); end
        cyc();
        rst = 1'b0;
        sample();
        n_vec++; if (tag_ready !== 1'b1) begin n_err++; $display("[TB] FAIL reset_release_tag_ready: got %0b required 1", tag_ready); end
    endtask

    task automatic test_basic_burst();
        logic [DATA_W-1:0] d;
        rready = 1'b1;
        cyc();
        tag_valid = 1'b1; tag_id = 4'd3; tag_len = 4'd3;
        cyc();
        tag_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d = DATA_W'(64'hA0 + i);
            set_beat(d, 1'b0);
            sb.push_back(mk_exp(4'd3, d, (i == 3), 2'b00));
            sample();
            if (i == 0) begin
                n_vec++; if (rvalid !== 1'b0) begin n_err++; $display("[TB] FAIL basic_rvalid_before_data: got %0b required 0", rvalid); end
            end else if (i == 1) begin
                n_vec++; if (rvalid !== 1'b1) begin n_err++; $display("[TB] FAIL basic_first_beat_latency: got %0b required 1", rvalid); end
            end
            cyc();
        end
        dfi_rddata_valid = 1'b0;
        drain("basic", 20);
        n_vec++; if (idle !== 1'b1) begin n_err++; $display("[TB] FAIL basic_idle_after: got %0b required 1", idle); end
        n_vec++; if (data_free !== FREE_W'(DATA_DEPTH)) begin n_err++; $display("[TB] FAIL basic_data_free_after: got %0d required %0d", data_free, DATA_DEPTH); end
    endtask

    task automatic test_overflow();
        logic [DATA_W-1:0] d;
        cyc();
        rready = 1'b0;
        tag_valid = 1'b1; tag_id = 4'd7; tag_len = 4'd15;
        cyc();
        tag_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            d = DATA_W'(64'hB000 + i);
            set_beat(d, 1'b0);
            sb.push_back(mk_exp(4'd7, d, (i == 15), 2'b00));
            cyc();
        end
        dfi_rddata_valid = 1'b0;
        sample();
        n_vec++; if (data_free !== '0) begin n_err++; $display("[TB] FAIL ovf_data_free_full: got %0d required 0", data_free); end
        n_vec++; if (ovf !== 1'b0) begin n_err++; $display("[TB] FAIL ovf_before_drop: got %0b required 0", ovf); end
        n_vec++; if (rvalid !== 1'b1 || rid !== 4'd7 || rdata !== DATA_W'(64'hB000) || rlast !== 1'b0) begin
            n_err++; $display("[TB] FAIL ovf_hold_head: got v=%0b id=%0h d=%h l=%0b required v=1 id=7 d=b000 l=0", rvalid, rid, rdata, rlast);
        end
        set_beat(DATA_W'(64'hDEAD), 1'b0);
        cyc();
        dfi_rddata_valid = 1'b0;
        sample();
        n_vec++; if (ovf !== 1'b1) begin n_err++; $display("[TB] FAIL ovf_set: got %0b required 1", ovf); end
        n_vec++; if (data_free !== '0) begin n_err++; $display("[TB] FAIL ovf_data_free_after_drop: got %0d required 0", data_free); end
        n_vec++; if (rdata !== DATA_W'(64'hB000) || rid !== 4'd7) begin n_err++; $display("[TB] FAIL ovf_head_stable: got id=%0h d=%h required id=7 d=b000", rid, rdata); end
        cyc();
        rready = 1'b1;
        drain("overflow", 40);
        n_vec++; if (ovf !== 1'b1) begin n_err++; $display("[TB] FAIL ovf_sticky: got %0b required 1", ovf); end
        n_vec++; if (data_free !== FREE_W'(DATA_DEPTH)) begin n_err++; $display("[TB] FAIL ovf_data_free_drained: got %0d required %0d", data_free, DATA_DEPTH); end
        n_vec++; if (idle !== 1'b1) begin n_err++; $display("[TB] FAIL ovf_idle_after: got %0b required 1", idle); end
    endtask

    task automatic test_data_first();
        cyc();
        rready = 1'b1;
        set_beat(DATA_W'(64'hC0), 1'b0);
        cyc();
        set_beat(DATA_W'(64'hC1), 1'b0);
        cyc();
        dfi_rddata_valid = 1'b0;
        sample();
        n_vec++; if (rvalid !== 1'b0) begin n_err++; $display("[TB] FAIL early_rvalid_no_tag: got %0b required 0", rvalid); end
        n_vec++; if (data_free !== FREE_W'(DATA_DEPTH - 2)) begin n_err++; $display("[TB] FAIL early_data_free: got %0d required %0d", data_free, DATA_DEPTH - 2); end
        cyc();
        sample();
        n_vec++; if (rvalid !== 1'b0 || idle !== 1'b0) begin n_err++; $display("[TB] FAIL early_waiting: got rvalid=%0b idle=%0b required rvalid=0 idle=0", rvalid, idle); end
        cyc();
        tag_valid = 1'b1; tag_id = 4'd5; tag_len = 4'd1;
        sb.push_back(mk_exp(4'd5, DATA_W'(64'hC0), 1'b0, 2'b00));
        sb.push_back(mk_exp(4'd5, DATA_W'(64'hC1), 1'b1, 2'b00));
        cyc();
        tag_valid = 1'b0;
        sample();
        n_vec++; if (rvalid !== 1'b0) begin n_err++; $display("[TB] FAIL early_rvalid_tag_edge: got %0b required 0", rvalid); end
        cyc();
        sample();
        n_vec++; if (rvalid !== 1'b1 || rid !== 4'd5) begin n_err++; $display("[TB] FAIL early_rvalid_after_tag: got rvalid=%0b rid=%0h required rvalid=1 rid=5", rvalid, rid); end
        drain("data_first", 20);
    endtask

    task automatic test_back_to_back();
        cyc();
        rready = 1'b1;
        tag_valid = 1'b1; tag_id = 4'd1; tag_len = 4'd0;
        sb.push_back(mk_exp(4'd1, DATA_W'(64'hD0), 1'b1, 2'b00));
        cyc();
        tag_id = 4'd2; tag_len = 4'd1;
        sb.push_back(mk_exp(4'd2, DATA_W'(64'hD1), 1'b0, 2'b00));
        sb.push_back(mk_exp(4'd2, DATA_W'(64'hD2), 1'b1, 2'b00));
        set_beat(DATA_W'(64'hD0), 1'b0);
        cyc();
        tag_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            if (i < 3) begin
                set_beat(DATA_W'(64'hD0 + i), 1'b0);
            end else begin
                dfi_rddata_valid = 1'b0;
            end
            sample();
            n_vec++; if (rvalid !== 1'b1 || idle !== 1'b0) begin
                n_err++; $display("[TB] FAIL b2b_no_gap_%0d: got rvalid=%0b idle=%0b required rvalid=1 idle=0", i, rvalid, idle);
            end
            cyc();
        end
        drain("back_to_back", 20);
        n_vec++; if (idle !== 1'b1) begin n_err++; $display("[TB] FAIL b2b_idle_after: got %0b required 1", idle); end
    endtask

    task automatic test_reset_midburst();
        cyc();
        rready = 1'b1;
        tag_valid = 1'b1; tag_id = 4'd9; tag_len = 4'd3;
        cyc();
        tag_valid = 1'b0;
        set_beat(DATA_W'(64'hE0), 1'b0);
        sb.push_back(mk_exp(4'd9, DATA_W'(64'hE0), 1'b0, 2'b00));
        cyc();
        set_beat(DATA_W'(64'hE1), 1'b0);
        sample();
        n_vec++; if (rvalid !== 1'b1) begin n_err++; $display("[TB] FAIL rstmid_burst_started: got %0b required 1", rvalid); end
        cyc();
        dfi_rddata_valid = 1'b0;
        rst = 1'b1;
        sample();
        n_vec++; if (rvalid !== 1'b0) begin n_err++; $display("[TB] FAIL rstmid_rvalid_in_reset: got %0b required 0", rvalid); end
        n_vec++; if (data_free !== FREE_W'(DATA_DEPTH)) begin n_err++; $display("[TB] FAIL rstmid_data_free_in_reset: got %0d required %0d", data_free, DATA_DEPTH); end
        n_vec++; if (tag_ready !== 1'b0) begin n_err++; $display("[TB] FAIL rstmid_tag_ready_in_reset: got %0b required 0", tag_ready); end
        cyc();
        rst = 1'b0;
        sample();
        n_vec++; if (tag_ready !== 1'b1) begin n_err++; $display("[TB] FAIL rstmid_tag_ready_after: got %0b required 1", tag_ready); end
        n_vec++; if (data_free !== FREE_W'(DATA_DEPTH)) begin n_err++; $display("[TB] FAIL rstmid_data_free_after: got %0d required %0d", data_free, DATA_DEPTH); end
        n_vec++; if (ovf !== 1'b0) begin n_err++; $display("[TB] FAIL rstmid_ovf_cleared: got %0b required 0", ovf); end
        n_vec++; if (idle !== 1'b1) begin n_err++; $display("[TB] FAIL rstmid_idle_after: got %0b required 1", idle); end
        for (int i = 0; i < 4; i++) begin
            cyc();
            sample();
            n_vec++; if (rvalid !== 1'b0) begin n_err++; $display("[TB] FAIL rstmid_residual_%0d: got rvalid=%0b required 0", i, rvalid); end
        end
        n_vec++; if (sb.size() != 0) begin n_err++; $display("[TB] FAIL rstmid_first_beat: got %0d pending required 0", sb.size()); sb.delete(); end
    endtask

`ifdef SAL_RD_PARITY_EN
    task automatic test_parity();
        logic [DATA_W-1:0] d;
        cyc();
        rready = 1'b1;
        tag_valid = 1'b1; tag_id = 4'd4; tag_len = 4'd3;
        cyc();
        tag_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d = DATA_W'(64'h0123_4567_89AB_CD00) + DATA_W'(i * 7);
            set_beat(d, (i == 1));
            sb.push_back(mk_exp(4'd4, d, (i == 3), (i == 1) ? 2'b10 : 2'b00));
            cyc();
        end
        dfi_rddata_valid = 1'b0;
        drain("parity", 20);
    endtask
`endif

    initial begin
        $display("[TB] sal_rd_return bench start");
        rst              = 1'b1;
        tag_valid        = 1'b0;
        tag_id           = '0;
        tag_len          = '0;
        dfi_rddata_valid = 1'b0;
        dfi_rddata       = '0;
`ifdef SAL_RD_PARITY_EN
        dfi_rddata_par   = '0;
`endif
        rready           = 1'b1;

        test_reset();
        test_basic_burst();
        test_overflow();
        test_data_first();
        test_back_to_back();
        test_reset_midburst();
`ifdef SAL_RD_PARITY_EN
        test_parity();
`endif
        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
